// File: rtl/hough_pkg.sv
// Shared definitions for the Hough video path.
package hough_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_RING   = 2'd2;

  localparam int LATENCY = 3;

endpackage

// File: rtl/circle_coord_counter.sv
// Raster x/y tracker for the overlay stage.
// Reports the position of the current beat and a saturation flag.
module circle_coord_counter #(
  parameter int COORD_W = 8
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               valid,
  input  logic               frame,
  input  logic               line,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               sat,
  output logic               load
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               fresh_q;
  logic [COORD_W-1:0] x_last;
  logic [COORD_W-1:0] y_last;

  assign x_last = width - ONE;
  assign y_last = height - ONE;
  assign load   = valid & frame;

  // Registers hold the last beat's position; the first beat is (0,0).
  always_comb begin
    cur_x = x_q;
    cur_y = y_q;
    sat   = 1'b0;
    if (frame || fresh_q) begin
      cur_x = '0;
      cur_y = '0;
    end else if (line) begin
      cur_x = '0;
      if (y_q == y_last) sat = valid;
      else cur_y = y_q + ONE;
    end else begin
      if (x_q == x_last) sat = valid;
      else cur_x = x_q + ONE;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x_q     <= '0;
      y_q     <= '0;
      fresh_q <= 1'b1;
    end else if (valid) begin
      x_q     <= cur_x;
      y_q     <= cur_y;
      fresh_q <= 1'b0;
    end
  end

endmodule

// File: rtl/circle_overlay_stage.sv
// Pixel-stream stage: per-frame pass, threshold or ring overlay.
// Three-stage pipeline with markers kept aligned to pixels.
module circle_overlay_stage
  import hough_pkg::*;
#(
  parameter int PIX_W   = 11,
  parameter int COORD_W = 8
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [PIX_W-1:0]   PixelIn,
  input  logic               ValidIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  input  logic [COORD_W-1:0] Width,
  input  logic [COORD_W-1:0] Height,
  input  logic [1:0]         Mode,
  input  logic [COORD_W-1:0] CentreX,
  input  logic [COORD_W-1:0] CentreY,
  input  logic [COORD_W-1:0] Radius,
  input  logic [PIX_W-1:0]   Threshold,
  input  logic [PIX_W-1:0]   MarkValue,
  output logic [PIX_W-1:0]   PixelOut,
  output logic               ValidOut,
  output logic               FrameOut,
  output logic               LineOut,
  output logic               GeomErr
);

  localparam int D2_W = 2 * COORD_W + 3;

  typedef struct packed {
    logic [1:0]         mode;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] radius;
    logic [PIX_W-1:0]   thresh;
    logic [PIX_W-1:0]   mark;
  } cfg_t;

  cfg_t               cfg_in;
  cfg_t               shadow_q;
  cfg_t               cfg;
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;

  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               sat;
  logic               load;

  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] f_q;
  logic [LATENCY-1:0] l_q;
  logic [LATENCY-1:0] e_q;

  circle_coord_counter #(
    .COORD_W(COORD_W)
  ) u_coord (
    .Clk   (Clk),
    .nReset(nReset),
    .valid (ValidIn),
    .frame (FrameIn),
    .line  (LineIn),
    .width (w_q),
    .height(h_q),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .sat   (sat),
    .load  (load)
  );

  always_comb begin
    cfg_in.mode   = Mode;
    cfg_in.cx     = CentreX;
    cfg_in.cy     = CentreY;
    cfg_in.radius = Radius;
    cfg_in.thresh = Threshold;
    cfg_in.mark   = MarkValue;
  end

  // The frame beat itself already uses the incoming config.
  assign cfg = load ? cfg_in : shadow_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      shadow_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else if (load) begin
      shadow_q <= cfg_in;
      w_q      <= Width;
      h_q      <= Height;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
      e_q <= '0;
    end else begin
      v_q <= {v_q[LATENCY-2:0], ValidIn};
      f_q <= {f_q[LATENCY-2:0], FrameIn & ValidIn};
      l_q <= {l_q[LATENCY-2:0], LineIn & ValidIn};
      e_q <= {e_q[LATENCY-2:0], sat};
    end
  end

  logic signed [COORD_W:0] dx_c;
  logic signed [COORD_W:0] dy_c;

  assign dx_c = $signed({1'b0, cur_x}) - $signed({1'b0, cfg.cx});
  assign dy_c = $signed({1'b0, cur_y}) - $signed({1'b0, cfg.cy});

  logic [PIX_W-1:0]        s1_pix;
  logic signed [COORD_W:0] s1_dx;
  logic signed [COORD_W:0] s1_dy;
  logic [1:0]              s1_mode;
  logic [COORD_W-1:0]      s1_r;
  logic [PIX_W-1:0]        s1_thr;
  logic [PIX_W-1:0]        s1_mark;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      s1_pix  <= '0;
      s1_dx   <= '0;
      s1_dy   <= '0;
      s1_mode <= '0;
      s1_r    <= '0;
      s1_thr  <= '0;
      s1_mark <= '0;
    end else begin
      s1_pix  <= PixelIn;
      s1_dx   <= dx_c;
      s1_dy   <= dy_c;
      s1_mode <= cfg.mode;
      s1_r    <= cfg.radius;
      s1_thr  <= cfg.thresh;
      s1_mark <= cfg.mark;
    end
  end

  logic signed [D2_W-1:0] dxe;
  logic signed [D2_W-1:0] dye;
  logic [D2_W-1:0]        d2_c;
  logic [D2_W-1:0]        re;
  logic [D2_W-1:0]        rsq;

  assign dxe  = {{(D2_W-COORD_W-1){s1_dx[COORD_W]}}, s1_dx};
  assign dye  = {{(D2_W-COORD_W-1){s1_dy[COORD_W]}}, s1_dy};
  assign d2_c = dxe * dxe + dye * dye;
  assign re   = {{(D2_W-COORD_W){1'b0}}, s1_r};
  assign rsq  = re * re;

  logic [PIX_W-1:0] s2_pix;
  logic [D2_W-1:0]  s2_d2;
  logic [D2_W-1:0]  s2_rlo;
  logic [D2_W-1:0]  s2_rhi;
  logic [1:0]       s2_mode;
  logic [PIX_W-1:0] s2_thr;
  logic [PIX_W-1:0] s2_mark;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      s2_pix  <= '0;
      s2_d2   <= '0;
      s2_rlo  <= '0;
      s2_rhi  <= '0;
      s2_mode <= '0;
      s2_thr  <= '0;
      s2_mark <= '0;
    end else begin
      s2_pix  <= s1_pix;
      s2_d2   <= d2_c;
      s2_rlo  <= rsq - re;
      s2_rhi  <= rsq + re;
      s2_mode <= s1_mode;
      s2_thr  <= s1_thr;
      s2_mark <= s1_mark;
    end
  end

  logic [PIX_W-1:0] mux_c;
  logic             ring_hit;
  logic [PIX_W-1:0] out_q;

  assign ring_hit = (s2_d2 >= s2_rlo) && (s2_d2 <= s2_rhi);

  always_comb begin
    mux_c = s2_pix;
    case (s2_mode)
      MODE_PASS:   mux_c = s2_pix;
      MODE_THRESH: mux_c = (s2_pix >= s2_thr) ? s2_mark : '0;
      MODE_RING:   mux_c = ring_hit ? s2_mark : s2_pix;
      default:     mux_c = s2_pix;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) out_q <= '0;
    else if (v_q[LATENCY-2]) out_q <= mux_c;
  end

  assign PixelOut = out_q;
  assign ValidOut = v_q[LATENCY-1];
  assign FrameOut = f_q[LATENCY-1];
  assign LineOut  = l_q[LATENCY-1];
  assign GeomErr  = e_q[LATENCY-1];

endmodule

// File: tb/tb_circle_overlay_stage.sv
// Bench for circle_overlay_stage: directed vectors, corner
// sequences and randomized frames against a reference model.
module tb_circle_overlay_stage;

  localparam int PIX_W   = 11;
  localparam int COORD_W = 8;

  logic               Clk = 1'b0;
  logic               nReset = 1'b0;
  logic [PIX_W-1:0]   PixelIn = '0;
  logic               ValidIn = 1'b0;
  logic               FrameIn = 1'b0;
  logic               LineIn = 1'b0;
  logic [COORD_W-1:0] Width = '0;
  logic [COORD_W-1:0] Height = '0;
  logic [1:0]         Mode = '0;
  logic [COORD_W-1:0] CentreX = '0;
  logic [COORD_W-1:0] CentreY = '0;
  logic [COORD_W-1:0] Radius = '0;
  logic [PIX_W-1:0]   Threshold = '0;
  logic [PIX_W-1:0]   MarkValue = '0;
  logic [PIX_W-1:0]   PixelOut;
  logic               ValidOut;
  logic               FrameOut;
  logic               LineOut;
  logic               GeomErr;

  always #5 Clk = ~Clk;

  circle_overlay_stage #(
    .PIX_W  (PIX_W),
    .COORD_W(COORD_W)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .PixelIn  (PixelIn),
    .ValidIn  (ValidIn),
    .FrameIn  (FrameIn),
    .LineIn   (LineIn),
    .Width    (Width),
    .Height   (Height),
    .Mode     (Mode),
    .CentreX  (CentreX),
    .CentreY  (CentreY),
    .Radius   (Radius),
    .Threshold(Threshold),
    .MarkValue(MarkValue),
    .PixelOut (PixelOut),
    .ValidOut (ValidOut),
    .FrameOut (FrameOut),
    .LineOut  (LineOut),
    .GeomErr  (GeomErr)
  );

  typedef struct {
    bit         v;
    bit         f;
    bit         l;
    bit         e;
    logic [10:0] pix;
  } exp_t;

  typedef struct {
    string name;
    int mode, w, h, cx, cy, r, thr, mark;
    int pix, tx, ty, want;
  } vec_t;

  exp_t q[$];
  int   cap[$];
  bit   cap_en = 1'b0;
  int   first_seen = -1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int mx, my;
  bit mfresh;
  int sh_mode, sh_cx, sh_cy, sh_r, sh_thr, sh_mark, sh_w, sh_h;
  logic [10:0] last_pix;

  function automatic void model_reset();
    exp_t e;
    e = '{default: 0};
    q.delete();
    q.push_back(e);
    q.push_back(e);
    mx = 0;
    my = 0;
    mfresh = 1'b1;
    sh_mode = 0; sh_cx = 0; sh_cy = 0; sh_r = 0;
    sh_thr = 0; sh_mark = 0; sh_w = 0; sh_h = 0;
    last_pix = '0;
  endfunction

  function automatic logic [10:0] model_pix(int pix);
    int d2, r2;
    logic [10:0] res;
    res = 11'(pix);
    if (sh_mode == 1) begin
      res = (pix >= sh_thr) ? 11'(sh_mark) : 11'd0;
    end else if (sh_mode == 2) begin
      d2 = (mx - sh_cx) * (mx - sh_cx) + (my - sh_cy) * (my - sh_cy);
      r2 = sh_r * sh_r;
      if (d2 >= r2 - sh_r && d2 <= r2 + sh_r) res = 11'(sh_mark);
    end
    return res;
  endfunction

  // Expected result for the beat currently on the inputs.
  function automatic void model_step();
    exp_t e;
    e = '{default: 0};
    if (nReset && ValidIn) begin
      e.v = 1'b1;
      e.f = FrameIn;
      e.l = LineIn;
      if (FrameIn) begin
        sh_mode = Mode; sh_cx = CentreX; sh_cy = CentreY;
        sh_r = Radius; sh_thr = Threshold; sh_mark = MarkValue;
        sh_w = Width; sh_h = Height;
        mx = 0; my = 0;
      end else if (mfresh) begin
        mx = 0; my = 0;
      end else if (LineIn) begin
        mx = 0;
        if (my == (sh_h + 255) % 256) e.e = 1'b1;
        else my = my + 1;
      end else begin
        if (mx == (sh_w + 255) % 256) e.e = 1'b1;
        else mx = mx + 1;
      end
      mfresh = 1'b0;
      e.pix = model_pix(int'(PixelIn));
    end
    q.push_back(e);
  endfunction

  function automatic void check_cycle();
    exp_t e;
    logic [14:0] got, want;
    e = q.pop_front();
    if (e.v) last_pix = e.pix;
    got  = {ValidOut, FrameOut, LineOut, GeomErr, PixelOut};
    want = {e.v, e.f, e.l, e.e, last_pix};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL cycle_check cyc=%0d: got v/f/l/e/pix=%b%b%b%b/%h required %b%b%b%b/%h",
               cyc, got[14], got[13], got[12], got[11], got[10:0],
               want[14], want[13], want[12], want[11], want[10:0]);
    end
  endfunction

  function automatic void expect_val(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    cyc++;
    check_cycle();
    if (cap_en && ValidOut) begin
      cap.push_back((int'(GeomErr) << 13) | (int'(FrameOut) << 12) |
                    (int'(LineOut) << 11) | int'(PixelOut));
      if (first_seen < 0) first_seen = cyc;
    end
  endtask

  task automatic send(int pix, bit f, bit l);
    ValidIn = 1'b1;
    PixelIn = PIX_W'(pix);
    FrameIn = f;
    LineIn  = l;
    tick();
  endtask

  task automatic idle(int n);
    ValidIn = 1'b0;
    FrameIn = 1'b0;
    LineIn  = 1'b0;
    repeat (n) begin
      PixelIn = PIX_W'($urandom_range(0, 2047));
      tick();
    end
  endtask

  task automatic set_cfg(int mode, int w, int h, int cx, int cy,
                         int r, int thr, int mark);
    Mode = 2'(mode); Width = 8'(w); Height = 8'(h);
    CentreX = 8'(cx); CentreY = 8'(cy); Radius = 8'(r);
    Threshold = 11'(thr); MarkValue = 11'(mark);
  endtask

  task automatic run_vec(vec_t v);
    int last;
    set_cfg(v.mode, v.w, v.h, v.cx, v.cy, v.r, v.thr, v.mark);
    last = v.ty * v.w + v.tx;
    for (int i = 0; i <= last; i++)
      send(v.pix, i == 0, (i > 0) && (i % v.w == 0));
    idle(2);
    expect_val(v.name, {ValidOut, PixelOut}, {1'b1, 11'(v.want)});
    idle(2);
  endtask

  task automatic rand_frame(bit bubbles, int stop_after);
    int w, h, n;
    w = $urandom_range(3, 6);
    h = $urandom_range(2, 4);
    set_cfg($urandom_range(0, 3), w, h, $urandom_range(0, w),
            $urandom_range(0, h), $urandom_range(0, 3),
            $urandom_range(0, 2047), $urandom_range(0, 2047));
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n == stop_after) return;
        if (bubbles) while ($urandom_range(0, 1) == 1) idle(1);
        send($urandom_range(0, 2047), x == 0 && y == 0, x == 0 && y > 0);
        n++;
        // Mid-frame config churn must not leak into this frame.
        if ($urandom_range(0, 3) == 0) begin
          Mode = 2'($urandom_range(0, 3));
          Radius = 8'($urandom_range(0, 3));
          CentreX = 8'($urandom_range(0, 6));
        end
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int want, dcyc;

    vecs[0]  = '{"ring_11_8",   2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  11, 8, 'h7FF};
    vecs[1]  = '{"ring_8_5",    2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  8,  5, 'h7FF};
    vecs[2]  = '{"ring_5_8",    2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  5,  8, 'h7FF};
    vecs[3]  = '{"ring_centre", 2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  8,  8, 5};
    vecs[4]  = '{"ring_origin", 2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  0,  0, 5};
    vecs[5]  = '{"ring_inside", 2, 16, 16, 8, 8, 3, 0,   'h7FF, 5,  9,  8, 5};
    vecs[6]  = '{"r0_centre",   2, 16, 16, 8, 8, 0, 0,   'h7FF, 5,  8,  8, 'h7FF};
    vecs[7]  = '{"r0_right",    2, 16, 16, 8, 8, 0, 0,   'h7FF, 5,  9,  8, 5};
    vecs[8]  = '{"thr_99",      1, 16, 16, 0, 0, 0, 100, 'h123, 99, 0,  0, 0};
    vecs[9]  = '{"thr_100",     1, 16, 16, 0, 0, 0, 100, 'h123, 100, 0, 0, 'h123};
    vecs[10] = '{"thr_101",     1, 16, 16, 0, 0, 0, 100, 'h123, 101, 0, 0, 'h123};
    vecs[11] = '{"mode3_pass",  3, 16, 16, 8, 8, 3, 0,   'h7FF, 42, 11, 8, 42};

    model_reset();
    #1;
    expect_val("reset_state", {ValidOut, FrameOut, LineOut, GeomErr, PixelOut}, 0);
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    idle(3);

    // Pass-through frame 4x3, latency and marker alignment
    set_cfg(0, 4, 3, 0, 0, 0, 0, 0);
    cap.delete();
    first_seen = -1;
    cap_en = 1'b1;
    dcyc = cyc;
    for (int i = 0; i < 12; i++) send(i, i == 0, (i > 0) && (i % 4 == 0));
    idle(4);
    cap_en = 1'b0;
    expect_val("pass_latency", first_seen - dcyc, 3);
    expect_val("pass_beats", cap.size(), 12);
    for (int k = 0; k < 12 && k < cap.size(); k++) begin
      want = k | (int'(k == 0) << 12) | (int'(k == 4 || k == 8) << 11);
      expect_val($sformatf("pass_beat%0d", k), cap[k], want);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mode change mid-frame waits for the next frame
    set_cfg(0, 4, 4, 1, 1, 1, 0, 'h7FF);
    for (int i = 0; i < 4; i++) send(5, i == 0, 1'b0);
    Mode = 2'd2;
    send(5, 1'b0, 1'b1);
    idle(2);
    expect_val("midframe_no_change", {ValidOut, PixelOut}, {1'b1, 11'd5});
    send(5, 1'b1, 1'b0);
    idle(2);
    expect_val("ring_from_origin", {ValidOut, PixelOut}, {1'b1, 11'h7FF});
    idle(2);

    // Saturation: x holds at Width-1, y holds at Height-1
    set_cfg(0, 4, 2, 0, 0, 0, 0, 0);
    cap.delete();
    cap_en = 1'b1;
    send(1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send(2 + i, 1'b0, 1'b0);
    send(7, 1'b0, 1'b1);
    send(8, 1'b0, 1'b1);
    idle(4);
    cap_en = 1'b0;
    want = 0;
    foreach (cap[k]) want |= ((cap[k] >> 13) & 1) << k;
    expect_val("geom_err_beats", (cap.size() << 8) | want, (8 << 8) | 'hB0);

    // Randomized frames with and without bubbles
    for (int f = 0; f < 6; f++) rand_frame(1'b1, 1000);
    for (int f = 0; f < 2; f++) rand_frame(1'b0, 1000);

    // Reset in the middle of a bubbly frame
    rand_frame(1'b1, 7);
    #2;
    nReset = 1'b0;
    #1;
    expect_val("reset_midframe", {ValidOut, FrameOut, LineOut, GeomErr, PixelOut}, 0);
    model_reset();
    ValidIn = 1'b1;
    PixelIn = 11'h55;
    tick();
    idle(1);
    nReset = 1'b1;
    idle(4);
    for (int f = 0; f < 2; f++) rand_frame(1'b1, 1000);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
